// File: rtl/m_bus_ctrl_pkg.sv
// Shared types for the M-stage data-bus controller: access sizes, exception codes,
// FSM states, load-extension ops and legality helpers.
package m_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    EXC_NONE    = 2'd0,
    EXC_ALIGN   = 2'd1,
    EXC_RANGE   = 2'd2,
    EXC_TIMEOUT = 2'd3
  } exc_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [2:0] DE_NONE = 3'd0;
  localparam logic [2:0] DE_LBU  = 3'd1;
  localparam logic [2:0] DE_LB   = 3'd2;
  localparam logic [2:0] DE_LHU  = 3'd3;
  localparam logic [2:0] DE_LH   = 3'd4;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SZ_W) && (addr_lo != 2'b00)) || ((size == SZ_H) && addr_lo[0]);
  endfunction

  // Borrow out of a 33-bit subtraction: a < b, with no constant-compare corner for b == 0.
  function automatic logic addr_lt(input logic [31:0] a, input logic [31:0] b);
    return 1'(({1'b0, a} - {1'b0, b}) >> 32);
  endfunction

endpackage

// File: rtl/m_bus_ctrl_be_gen.sv
// Byte-enable and store-lane generator: maps size and low address bits to bus
// byte enables and replicates store data across the lanes.
module m_be_gen
  import m_bus_ctrl_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        store_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  byteen_o,
  output logic [31:0] wdata_o
);

  always_comb begin
    byteen_o = 4'b0000;
    wdata_o  = wdata_i;
    case (size_i)
      SZ_W: byteen_o = 4'b1111;
      SZ_H: begin
        byteen_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        wdata_o  = {2{wdata_i[15:0]}};
      end
      SZ_B: begin
        byteen_o = 4'b0001 << addr_lo_i;
        wdata_o  = {4{wdata_i[7:0]}};
      end
      default: ;
    endcase
    if (!store_i) begin
      byteen_o = 4'b0000;
    end
  end

endmodule

// File: rtl/m_bus_ctrl.sv
// M-stage data-bus controller: legality checks, held word-aligned bus request with
// timeout, pipeline stall, and latched results for the load-extension unit.
module m_bus_ctrl
  import m_bus_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_2FFF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_store,
  input  logic [1:0]  i_size,
  input  logic [2:0]  i_de_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic        o_m_data_req,
  output logic [31:0] o_m_data_addr,
  output logic [31:0] o_m_data_wdata,
  output logic [3:0]  o_m_data_byteen,
  input  logic        i_m_data_ack,
  input  logic [31:0] i_m_data_rdata,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_de_op,
  output logic [31:0] o_addr,
  output logic [1:0]  o_exc
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  exc_e            exc_q, exc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            store_q, store_d;
  logic [31:0]     bus_addr_q, bus_addr_d;
  logic [31:0]     bus_wdata_q, bus_wdata_d;
  logic [3:0]      byteen_q, byteen_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     addr_q, addr_d;
  logic [2:0]      de_op_q, de_op_d;

  logic [3:0]      be_byteen;
  logic [31:0]     be_wdata;
  logic            misaligned, out_of_range;

  m_be_gen u_be_gen (
    .size_i   (i_size),
    .addr_lo_i(i_addr[1:0]),
    .store_i  (i_req_store),
    .wdata_i  (i_wdata),
    .byteen_o (be_byteen),
    .wdata_o  (be_wdata)
  );

  always_comb begin
    misaligned   = is_misaligned(i_size, i_addr[1:0]);
    out_of_range = addr_lt(i_addr, ADDR_LO) || addr_lt(ADDR_HI, i_addr);

    state_d     = state_q;
    exc_d       = exc_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    byteen_d    = byteen_q;
    rdata_d     = rdata_q;
    addr_d      = addr_q;
    de_op_d     = de_op_q;

    unique case (state_q)
      StIdle: begin
        if (i_req_valid) begin
          addr_d  = i_addr;
          de_op_d = i_de_op;
          if (misaligned || out_of_range) begin
            exc_d   = misaligned ? EXC_ALIGN : EXC_RANGE;
            rdata_d = '0;
            state_d = StDone;
          end else begin
            bus_addr_d  = {i_addr[31:2], 2'b00};
            bus_wdata_d = be_wdata;
            byteen_d    = be_byteen;
            store_d     = i_req_store;
            cnt_d       = '0;
            state_d     = StReq;
          end
        end
      end
      StReq: begin
        // ack is checked first so it wins over a simultaneous timeout
        if (i_m_data_ack) begin
          rdata_d = store_q ? '0 : i_m_data_rdata;
          exc_d   = EXC_NONE;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT)) begin
          rdata_d = '0;
          exc_d   = EXC_TIMEOUT;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      exc_q       <= EXC_NONE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      byteen_q    <= '0;
      rdata_q     <= '0;
      addr_q      <= '0;
      de_op_q     <= '0;
    end else begin
      state_q     <= state_d;
      exc_q       <= exc_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      byteen_q    <= byteen_d;
      rdata_q     <= rdata_d;
      addr_q      <= addr_d;
      de_op_q     <= de_op_d;
    end
  end

  assign o_stall         = ((state_q == StIdle) && i_req_valid) || (state_q == StReq);
  assign o_m_data_req    = (state_q == StReq);
  assign o_done          = (state_q == StDone);
  assign o_m_data_addr   = bus_addr_q;
  assign o_m_data_wdata  = bus_wdata_q;
  assign o_m_data_byteen = byteen_q;
  assign o_rdata         = rdata_q;
  assign o_de_op         = de_op_q;
  assign o_addr          = addr_q;
  assign o_exc           = exc_q;

endmodule

// File: tb/tb_m_bus_ctrl.sv
// Bench for m_bus_ctrl: directed vector table, reset/back-to-back sequences and
// random transactions checked against a transaction-level model.
module tb_m_bus_ctrl;
  import m_bus_ctrl_pkg::*;

  localparam logic [31:0] TbLo = 32'h0000_0000;
  localparam logic [31:0] TbHi = 32'h0000_2FFF;
  localparam int          TbTo = 4;
  localparam int          Never = 255;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  de_op;
    int          ack_wait;
    logic [31:0] rdata;
    logic [1:0]  e_exc;
    logic [3:0]  e_byteen;
    logic [31:0] e_wdata;
    int          e_stall;
    int          e_req;
    logic [31:0] e_rdata;
    logic        chk_rdata;
  } txn_t;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_store = 1'b0;
  logic [1:0]  i_size = 2'b00;
  logic [2:0]  i_de_op = 3'd0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        i_m_data_ack = 1'b0;
  logic [31:0] i_m_data_rdata = '0;
  logic        o_stall, o_m_data_req, o_done;
  logic [31:0] o_m_data_addr, o_m_data_wdata, o_rdata, o_addr;
  logic [3:0]  o_m_data_byteen;
  logic [2:0]  o_de_op;
  logic [1:0]  o_exc;

  int n_chk = 0;
  int n_err = 0;

  m_bus_ctrl #(
    .ADDR_LO(TbLo),
    .ADDR_HI(TbHi),
    .TIMEOUT(TbTo)
  ) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .i_req_store    (i_req_store),
    .i_size         (i_size),
    .i_de_op        (i_de_op),
    .i_addr         (i_addr),
    .i_wdata        (i_wdata),
    .o_stall        (o_stall),
    .o_m_data_req   (o_m_data_req),
    .o_m_data_addr  (o_m_data_addr),
    .o_m_data_wdata (o_m_data_wdata),
    .o_m_data_byteen(o_m_data_byteen),
    .i_m_data_ack   (i_m_data_ack),
    .i_m_data_rdata (i_m_data_rdata),
    .o_done         (o_done),
    .o_rdata        (o_rdata),
    .o_de_op        (o_de_op),
    .o_addr         (o_addr),
    .o_exc          (o_exc)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level reference: expected bus lanes, exception and cycle counts.
  function automatic txn_t model(input txn_t t);
    txn_t r = t;
    bit mis = (t.size == SZ_W && (t.addr % 4) != 0) || (t.size == SZ_H && (t.addr % 2) != 0);
    bit oor = (longint'(t.addr) < longint'(TbLo)) || (longint'(t.addr) > longint'(TbHi));
    r.e_byteen  = 4'h0;
    r.e_wdata   = t.wdata;
    r.e_rdata   = 32'h0;
    r.chk_rdata = 1'b1;
    if (mis || oor) begin
      r.e_exc   = mis ? EXC_ALIGN : EXC_RANGE;
      r.e_req   = 0;
      r.e_stall = 1;
      return r;
    end
    if (t.size == SZ_W) r.e_byteen = 4'hF;
    else if (t.size == SZ_H) r.e_byteen = 4'(3 << (t.addr & 2));
    else r.e_byteen = 4'(1 << (t.addr % 4));
    if (!t.store) r.e_byteen = 4'h0;
    if (t.size == SZ_H) r.e_wdata = (t.wdata & 32'hFFFF) * 32'h0001_0001;
    if (t.size == SZ_B) r.e_wdata = (t.wdata & 32'hFF) * 32'h0101_0101;
    if (t.ack_wait <= TbTo) begin
      r.e_exc   = EXC_NONE;
      r.e_req   = t.ack_wait + 1;
      r.e_rdata = t.store ? 32'h0 : t.rdata;
    end else begin
      r.e_exc     = EXC_TIMEOUT;
      r.e_req     = TbTo + 1;
      r.chk_rdata = 1'b0;
    end
    r.e_stall = 1 + r.e_req;
    return r;
  endfunction

  // Holds the instruction through DONE; returns one cycle after the DONE edge.
  task automatic do_txn(input string tag, input txn_t t);
    int stalls = 0;
    int reqs = 0;
    bit done = 1'b0;
    bit bus_ok = 1'b1;
    logic [1:0]  exc_s = '0;
    logic [31:0] addr_s = '0;
    logic [31:0] rdata_s = '0;
    logic [2:0]  de_s = '0;
    i_req_valid = 1'b1;
    i_req_store = t.store;
    i_size      = t.size;
    i_addr      = t.addr;
    i_wdata     = t.wdata;
    i_de_op     = t.de_op;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      #1;
      if (o_m_data_req) begin
        i_m_data_ack   = (reqs == t.ack_wait);
        i_m_data_rdata = t.rdata;
        if (o_m_data_addr !== {t.addr[31:2], 2'b00} || o_m_data_byteen !== t.e_byteen ||
            (t.store && o_m_data_wdata !== t.e_wdata)) bus_ok = 1'b0;
        reqs++;
      end else begin
        i_m_data_ack   = 1'b0;
        i_m_data_rdata = $urandom;
      end
      if (o_stall) stalls++;
      if (o_done) begin
        done    = 1'b1;
        exc_s   = o_exc;
        addr_s  = o_addr;
        rdata_s = o_rdata;
        de_s    = o_de_op;
      end
      @(posedge i_clk);
      #1;
    end
    i_m_data_ack = 1'b0;
    chk({tag, ".done_seen"}, 32'(done), 32'd1);
    chk({tag, ".stall_cycles"}, stalls, t.e_stall);
    chk({tag, ".req_cycles"}, reqs, t.e_req);
    if (t.e_req > 0) chk({tag, ".bus_fields"}, 32'(bus_ok), 32'd1);
    chk({tag, ".exc"}, 32'(exc_s), 32'(t.e_exc));
    chk({tag, ".o_addr"}, addr_s, t.addr);
    chk({tag, ".de_op"}, 32'(de_s), 32'(t.de_op));
    if (t.chk_rdata) chk({tag, ".rdata"}, rdata_s, t.e_rdata);
  endtask

  // Idle slots; ack is toggled to show it is ignored while no request is out.
  task automatic idle(input int n);
    i_req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      i_m_data_ack   = 1'($urandom);
      i_m_data_rdata = $urandom;
      #1;
      chk("idle.stall", 32'(o_stall), 32'd0);
      chk("idle.req", 32'(o_m_data_req), 32'd0);
      chk("idle.done", 32'(o_done), 32'd0);
      @(posedge i_clk);
      #1;
    end
    i_m_data_ack = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".req"}, 32'(o_m_data_req), 32'd0);
    chk({tag, ".done"}, 32'(o_done), 32'd0);
    chk({tag, ".rdata"}, o_rdata, 32'd0);
    chk({tag, ".addr"}, o_addr, 32'd0);
    chk({tag, ".bus_addr"}, o_m_data_addr, 32'd0);
    chk({tag, ".bus_wdata"}, o_m_data_wdata, 32'd0);
    chk({tag, ".byteen"}, 32'(o_m_data_byteen), 32'd0);
    chk({tag, ".de_op"}, 32'(o_de_op), 32'd0);
    chk({tag, ".exc"}, 32'(o_exc), 32'(EXC_NONE));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    txn_t vec[12];
    txn_t t;
    vec[0]  = '{1'b0, SZ_W, 32'h104, 32'h0, 3'd2, 0, 32'hDEADBEEF,
                EXC_NONE, 4'h0, 32'h0, 2, 1, 32'hDEADBEEF, 1'b1};
    vec[1]  = '{1'b1, SZ_B, 32'h203, 32'hA5, 3'd0, 3, 32'h1111_1111,
                EXC_NONE, 4'b1000, 32'hA5A5_A5A5, 5, 4, 32'h0, 1'b1};
    vec[2]  = '{1'b1, SZ_H, 32'h202, 32'h1234, 3'd0, 3, 32'h2222_2222,
                EXC_NONE, 4'b1100, 32'h1234_1234, 5, 4, 32'h0, 1'b1};
    vec[3]  = '{1'b0, SZ_W, 32'h102, 32'h0, 3'd1, 0, 32'h3333_3333,
                EXC_ALIGN, 4'h0, 32'h0, 1, 0, 32'h0, 1'b1};
    vec[4]  = '{1'b0, SZ_W, 32'h3000, 32'h0, 3'd3, 0, 32'h4444_4444,
                EXC_RANGE, 4'h0, 32'h0, 1, 0, 32'h0, 1'b1};
    vec[5]  = '{1'b0, SZ_W, 32'h10, 32'h0, 3'd4, Never, 32'h5555_5555,
                EXC_TIMEOUT, 4'h0, 32'h0, 6, 5, 32'h0, 1'b0};
    vec[6]  = '{1'b0, SZ_W, 32'h14, 32'h0, 3'd4, 4, 32'hCAFE_F00D,
                EXC_NONE, 4'h0, 32'h0, 6, 5, 32'hCAFE_F00D, 1'b1};
    vec[7]  = '{1'b1, SZ_W, 32'h2FFC, 32'h89AB_CDEF, 3'd0, 0, 32'h0,
                EXC_NONE, 4'hF, 32'h89AB_CDEF, 2, 1, 32'h0, 1'b1};
    vec[8]  = '{1'b0, SZ_H, 32'h1, 32'h0, 3'd3, 0, 32'h0,
                EXC_ALIGN, 4'h0, 32'h0, 1, 0, 32'h0, 1'b1};
    vec[9]  = '{1'b0, SZ_B, 32'h2FFF, 32'h0, 3'd1, 1, 32'h0000_00FE,
                EXC_NONE, 4'h0, 32'h0, 3, 2, 32'h0000_00FE, 1'b1};
    vec[10] = '{1'b1, SZ_H, 32'h3001, 32'h5678, 3'd0, 0, 32'h0,
                EXC_ALIGN, 4'h0, 32'h0, 1, 0, 32'h0, 1'b1};
    vec[11] = '{1'b1, SZ_B, 32'h3000, 32'h77, 3'd0, 0, 32'h0,
                EXC_RANGE, 4'h0, 32'h0, 1, 0, 32'h0, 1'b1};

    #3;
    chk_zero("reset0");
    chk("reset0.stall", 32'(o_stall), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;

    // Directed table; vec[0] and vec[1] run back-to-back.
    foreach (vec[i]) begin
      do_txn($sformatf("vec%0d", i), vec[i]);
      if (i != 0) idle(1);
    end

    // Two loads in consecutive M slots.
    do_txn("b2b_a", vec[0]);
    do_txn("b2b_b", vec[9]);
    idle(1);

    // Reset while the request is outstanding after two wait cycles.
    i_req_valid = 1'b1;
    i_req_store = 1'b0;
    i_size      = SZ_W;
    i_addr      = 32'h400;
    i_de_op     = 3'd5;
    i_wdata     = 32'h0;
    @(posedge i_clk);
    #1;
    chk("rst.req_on", 32'(o_m_data_req), 32'd1);
    @(posedge i_clk);
    #1;
    @(posedge i_clk);
    #1;
    chk("rst.req_held", 32'(o_m_data_req), 32'd1);
    i_reset = 1'b1;
    #1;
    chk_zero("rst");
    chk("rst.stall_follows", 32'(o_stall), 32'd1);
    i_req_valid = 1'b0;
    #1;
    chk("rst.stall_off", 32'(o_stall), 32'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    do_txn("after_rst", vec[6]);
    idle(1);

    // Random transactions against the model.
    for (int n = 0; n < 40; n++) begin
      t.store    = 1'($urandom);
      t.size     = 2'($urandom_range(0, 2));
      t.addr     = $urandom_range(0, 32'h3100);
      if ($urandom_range(0, 1) == 1) begin
        if (t.size == SZ_W) t.addr = t.addr & ~32'h3;
        if (t.size == SZ_H) t.addr = t.addr & ~32'h1;
      end
      if ($urandom_range(0, 7) == 0) t.addr = $urandom;
      t.wdata    = $urandom;
      t.de_op    = 3'($urandom);
      t.ack_wait = $urandom_range(0, 6);
      t.rdata    = $urandom;
      t = model(t);
      do_txn($sformatf("rnd%0d", n), t);
      idle($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
